// File: rtl/tdm_demultiplexer2.sv
// Two-lane TDM receiver: splits an interleaved serial stream into two WIDTH-bit
// words (even slots -> out0, odd slots -> out1, MSB first) with a valid pulse.
module tdm_demultiplexer2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic             en,
  input  logic             frame,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic             valid,
  output logic             err,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             slot;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sh0;
  logic [WIDTH-1:0] sh1;
  logic             last_bit;

  // The sampled bit that completes a frame: lane1 slot of the final bit pair.
  assign last_bit = en && (state == RECV) && !frame && slot && (count == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en && frame) state_nxt = RECV;
      RECV:    if (last_bit)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RECV);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out0  <= '0;
      out1  <= '0;
      valid <= 1'b0;
      err   <= 1'b0;
      slot  <= 1'b0;
      count <= '0;
      sh0   <= '0;
      sh1   <= '0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (en) begin
        if (frame) begin
          // A marker always starts a fresh frame; inside RECV it also flags resync.
          sh0   <= {sh0[WIDTH-2:0], in};
          slot  <= 1'b1;
          count <= '0;
          err   <= (state == RECV);
        end else if (state == RECV) begin
          if (!slot) begin
            sh0  <= {sh0[WIDTH-2:0], in};
            slot <= 1'b1;
          end else begin
            sh1  <= {sh1[WIDTH-2:0], in};
            slot <= 1'b0;
            if (count == LAST) begin
              out0  <= sh0;
              out1  <= {sh1[WIDTH-2:0], in};
              valid <= 1'b1;
              count <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
